wb_rst_seq: RTL and testbench

//   Wishbone SYSCON reset generator. Merges the system reset with N_SRC reset

---
 rtl/wb_rst_seq_pkg.sv | 25 ++
 rtl/wb_rst_seq.sv | 145 ++++++++++++++
 tb/tb_wb_rst_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_rst_seq_pkg.sv
// Shared types and helpers for the Wishbone SYSCON reset sequencer.
package wb_rst_seq_pkg;

   // Sequencer state: RUN = all resets released, HOLD = rst_o[0] held,
   // STAGE = releasing higher stages one by one.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      STAGE = 2'd2
   } wb_rst_seq_state_t;

   // Counter width large enough for the longer of the two intervals,
   // never narrower than one bit.
   function automatic int cnt_width(input int hold, input int gap);
      int m;
      m = (hold > gap) ? hold : gap;
      cnt_width = (m > 1) ? $clog2(m) : 1;
   endfunction

   // Width of the stage index, never narrower than one bit.
   function automatic int stage_width(input int stages);
      stage_width = (stages > 1) ? $clog2(stages) : 1;
   endfunction

endpackage

// File: rtl/wb_rst_seq.sv
// Wishbone SYSCON reset generator: merges the system reset with level
// reset requests and releases staged rst_o outputs in index order after a
// minimum hold time. All outputs come straight from flops.
module wb_rst_seq
   import wb_rst_seq_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int STAGES      = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic              clk_i,
   input  logic              sync_rst_i,
   input  logic [N_SRC-1:0]  rst_req_i,
   input  logic              cause_clr_i,
   output logic [STAGES-1:0] rst_o,
   output logic              busy_o,
   output logic [N_SRC:0]    cause_o
);

   localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int SW = stage_width(STAGES);

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [SW-1:0] STAGE_ONE  = SW'(1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);

   // Elaboration-time parameter range checks.
   if (N_SRC < 1) begin : g_bad_n_src
      $error("wb_rst_seq: N_SRC must be >= 1");
   end
   if (STAGES < 1) begin : g_bad_stages
      $error("wb_rst_seq: STAGES must be >= 1");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("wb_rst_seq: HOLD_CYCLES must be >= 1");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("wb_rst_seq: GAP_CYCLES must be >= 1");
   end

   wb_rst_seq_state_t state_r, state_nxt_s;
   logic [CW-1:0]     cnt_r, cnt_nxt_s;
   logic [SW-1:0]     stage_r, stage_nxt_s;
   logic [STAGES-1:0] rst_r, rst_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic [N_SRC:0]    cause_r, cause_nxt_s;

   // Next-state, counter, stage and cause computation.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      stage_nxt_s = stage_r;
      rst_nxt_s   = rst_r;
      busy_nxt_s  = busy_r;

      // Clear only when idle; a request arriving with the clear survives.
      if ((state_r == RUN) && cause_clr_i) begin
         cause_nxt_s = {1'b0, rst_req_i};
      end else begin
         cause_nxt_s = cause_r | {1'b0, rst_req_i};
      end

      if (|rst_req_i) begin
         // Any request restarts the whole sequence from the top.
         state_nxt_s = HOLD;
         cnt_nxt_s   = '0;
         stage_nxt_s = '0;
         rst_nxt_s   = '1;
         busy_nxt_s  = 1'b1;
      end else begin
         case (state_r)
            HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  rst_nxt_s[0] = 1'b0;
                  cnt_nxt_s    = '0;
                  stage_nxt_s  = STAGE_ONE;
                  if (STAGES == 1) begin
                     state_nxt_s = RUN;
                     busy_nxt_s  = 1'b0;
                  end else begin
                     state_nxt_s = STAGE;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            STAGE: begin
               if (cnt_r == GAP_LAST) begin
                  rst_nxt_s[stage_r] = 1'b0;
                  cnt_nxt_s          = '0;
                  if (stage_r == STAGE_LAST) begin
                     state_nxt_s = RUN;
                     busy_nxt_s  = 1'b0;
                     stage_nxt_s = '0;
                  end else begin
                     stage_nxt_s = stage_r + STAGE_ONE;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            RUN: begin
               rst_nxt_s  = '0;
               busy_nxt_s = 1'b0;
               cnt_nxt_s  = '0;
            end
            default: begin
               // Illegal encoding: fall back to a full reset sequence.
               state_nxt_s = HOLD;
               cnt_nxt_s   = '0;
               stage_nxt_s = '0;
               rst_nxt_s   = '1;
               busy_nxt_s  = 1'b1;
            end
         endcase
      end
   end

   // State registers with synchronous system reset taking priority.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_r <= HOLD;
         cnt_r   <= '0;
         stage_r <= '0;
         rst_r   <= '1;
         busy_r  <= 1'b1;
         cause_r <= {1'b1, {N_SRC{1'b0}}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         stage_r <= stage_nxt_s;
         rst_r   <= rst_nxt_s;
         busy_r  <= busy_nxt_s;
         cause_r <= cause_nxt_s;
      end
   end

   assign rst_o   = rst_r;
   assign busy_o  = busy_r;
   assign cause_o = cause_r;

endmodule

// File: tb/tb_wb_rst_seq.sv
// Directed, table-driven bench for wb_rst_seq with default parameters.
module tb_wb_rst_seq;

   logic       clk;
   logic       sync_rst;
   logic [3:0] req;
   logic       clr;
   logic [1:0] rst;
   logic       busy;
   logic [4:0] cause;

   int checks   = 0;
   int failures = 0;
   logic       started = 1'b0;
   logic [4:0] exp_cause;

   typedef struct {
      int         n;
      logic       srst;
      logic [3:0] req;
      logic       clr;
      logic [1:0] rst;
      logic       busy;
      logic [4:0] cause;
   } vec_t;

   vec_t tbl[$];

   wb_rst_seq #(
      .N_SRC(4), .STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(4)
   ) dut (
      .clk_i(clk),
      .sync_rst_i(sync_rst),
      .rst_req_i(req),
      .cause_clr_i(clr),
      .rst_o(rst),
      .busy_o(busy),
      .cause_o(cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Structural invariants sampled away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if ((busy !== (|rst)) || (rst[0] === 1'b1 && rst[1] === 1'b0)) begin
            failures++;
            $display("FAIL invariant rst=%b busy=%b (need busy==|rst, rst[1]=0 -> rst[0]=0)", rst, busy);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      started = 1'b1;
   endtask

   task automatic check(input string name, input logic [1:0] e_rst,
                        input logic e_busy, input logic [4:0] e_cause);
      checks++;
      if (rst !== e_rst || busy !== e_busy || cause !== e_cause) begin
         failures++;
         $display("FAIL %s rst=%b/%b busy=%b/%b cause=%b/%b (got/expected)",
                  name, rst, e_rst, busy, e_busy, cause, e_cause);
      end
   endtask

   // Release sequence after the last active edge: 15 more edges of 11,
   // rst[0] drops on the 16th, rst[1] four edges later.
   task automatic run_release(input string name);
      for (int i = 0; i < 15; i++) begin
         tick(); check({name, "_hold"}, 2'b11, 1'b1, exp_cause);
      end
      tick(); check({name, "_rel0"}, 2'b10, 1'b1, exp_cause);
      for (int i = 0; i < 3; i++) begin
         tick(); check({name, "_gap"}, 2'b10, 1'b1, exp_cause);
      end
      tick(); check({name, "_rel1"}, 2'b00, 1'b0, exp_cause);
      tick(); check({name, "_run"}, 2'b00, 1'b0, exp_cause);
   endtask

   initial begin
      sync_rst = 1'b0;
      req      = 4'b0000;
      clr      = 1'b0;

      // n, srst, req, clr, expected rst, busy, cause (checked after each edge)
      // Power-on reset and release.
      tbl.push_back('{3,  1'b1, 4'b0000, 1'b0, 2'b11, 1'b1, 5'b10000});
      tbl.push_back('{15, 1'b0, 4'b0000, 1'b0, 2'b11, 1'b1, 5'b10000});
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b0, 2'b10, 1'b1, 5'b10000});
      tbl.push_back('{3,  1'b0, 4'b0000, 1'b0, 2'b10, 1'b1, 5'b10000});
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 5'b10000});
      tbl.push_back('{3,  1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 5'b10000});
      // One-cycle pulse on request 2 from RUN.
      tbl.push_back('{1,  1'b0, 4'b0100, 1'b0, 2'b11, 1'b1, 5'b10100});
      tbl.push_back('{15, 1'b0, 4'b0000, 1'b0, 2'b11, 1'b1, 5'b10100});
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b0, 2'b10, 1'b1, 5'b10100});
      tbl.push_back('{3,  1'b0, 4'b0000, 1'b0, 2'b10, 1'b1, 5'b10100});
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 5'b10100});
      // Clear in RUN, then clear together with request 1.
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b1, 2'b00, 1'b0, 5'b00000});
      tbl.push_back('{1,  1'b0, 4'b0010, 1'b1, 2'b11, 1'b1, 5'b00010});
      // Clear ignored in HOLD.
      tbl.push_back('{3,  1'b0, 4'b0000, 1'b1, 2'b11, 1'b1, 5'b00010});
      tbl.push_back('{12, 1'b0, 4'b0000, 1'b0, 2'b11, 1'b1, 5'b00010});
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b1, 2'b10, 1'b1, 5'b00010});
      // Clear ignored in STAGE, including the final release edge.
      tbl.push_back('{3,  1'b0, 4'b0000, 1'b1, 2'b10, 1'b1, 5'b00010});
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b1, 2'b00, 1'b0, 5'b00010});
      // Now in RUN: clear takes effect.
      tbl.push_back('{1,  1'b0, 4'b0000, 1'b1, 2'b00, 1'b0, 5'b00000});
      tbl.push_back('{2,  1'b0, 4'b0000, 1'b0, 2'b00, 1'b0, 5'b00000});

      for (int i = 0; i < tbl.size(); i++) begin
         sync_rst = tbl[i].srst;
         req      = tbl[i].req;
         clr      = tbl[i].clr;
         for (int j = 0; j < tbl[i].n; j++) begin
            tick();
            check($sformatf("vec%0d_%0d", i, j), tbl[i].rst, tbl[i].busy, tbl[i].cause);
         end
      end
      sync_rst = 1'b0;
      req      = 4'b0000;
      clr      = 1'b0;

      // Request during STAGE restarts the full sequence.
      exp_cause = 5'b00001;
      req = 4'b0001;
      tick(); check("stg_req", 2'b11, 1'b1, exp_cause);
      req = 4'b0000;
      for (int i = 0; i < 15; i++) begin
         tick(); check("stg_hold", 2'b11, 1'b1, exp_cause);
      end
      tick(); check("stg_rel0", 2'b10, 1'b1, exp_cause);
      tick(); check("stg_wait", 2'b10, 1'b1, exp_cause);
      req = 4'b0001;
      tick(); check("stg_restart", 2'b11, 1'b1, exp_cause);
      req = 4'b0000;
      run_release("stg_seq");

      // Long request holds everything in reset.
      exp_cause = 5'b01001;
      req = 4'b1000;
      for (int i = 0; i < 100; i++) begin
         tick(); check("long_req", 2'b11, 1'b1, exp_cause);
      end
      req = 4'b0000;
      run_release("long_seq");

      // System reset from RUN replaces the cause with the reset bit only.
      sync_rst = 1'b1;
      tick(); check("rerst", 2'b11, 1'b1, 5'b10000);
      sync_rst = 1'b0;
      tick(); check("rerst_hold", 2'b11, 1'b1, 5'b10000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
